// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares single-port DMEM between CPU MEM stage and NIC DMA port;
//            CPU has default priority, a starvation counter forces NIC wins.
// Options  : DMEM_ARB_STAT_EN adds a saturating 16-bit conflict counter port.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 64,
   parameter int NIC_WAIT_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_memEn,
   input  logic              cpu_memwrEn,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              nic_req,
   input  logic              nic_we,
   input  logic [ADDR_W-1:0] nic_addr,
   input  logic [DATA_W-1:0] nic_wdata,
   output logic              nic_gnt,
   output logic [DATA_W-1:0] nic_rdata,
   output logic              nic_rvalid,
   output logic              dmem_en,
   output logic              dmem_wrEn,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata
`ifdef DMEM_ARB_STAT_EN
   ,
   output logic [15:0]       conflict_cnt
`endif
);

   typedef enum logic [0:0] {
      CPU_PRI = 1'b0,
      NIC_PRI = 1'b1
   } state_t;

   localparam logic [3:0] c_WAIT_MAX = 4'(NIC_WAIT_MAX);

   state_t     r_state;
   logic [3:0] r_wait;
   logic       r_rd_vld;
   logic       r_rd_nic;

   logic       w_nic_gnt;
   logic       w_cpu_gnt;
   logic [3:0] w_wait_nxt;

   assign w_nic_gnt = nic_req & (~cpu_memEn | (r_state == NIC_PRI));
   assign w_cpu_gnt = cpu_memEn & ~w_nic_gnt;

   assign nic_gnt   = w_nic_gnt;
   assign cpu_stall = cpu_memEn & ~w_cpu_gnt;

   assign dmem_en    = w_cpu_gnt | w_nic_gnt;
   assign dmem_wrEn  = w_nic_gnt ? nic_we    : (w_cpu_gnt & cpu_memwrEn);
   assign dmem_addr  = w_nic_gnt ? nic_addr  : (w_cpu_gnt ? cpu_addr  : '0);
   assign dmem_wdata = w_nic_gnt ? nic_wdata : (w_cpu_gnt ? cpu_wdata : '0);

   // Denied-cycle count saturates so a long starvation never wraps back to 0.
   always_comb begin
      w_wait_nxt = 4'd0;
      if (nic_req && !w_nic_gnt) begin
         w_wait_nxt = (r_wait >= c_WAIT_MAX) ? c_WAIT_MAX : r_wait + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= CPU_PRI;
         r_wait   <= 4'd0;
         r_rd_vld <= 1'b0;
         r_rd_nic <= 1'b0;
      end else begin
         r_wait   <= w_wait_nxt;
         r_rd_vld <= (w_cpu_gnt & ~cpu_memwrEn) | (w_nic_gnt & ~nic_we);
         r_rd_nic <= w_nic_gnt;
         case (r_state)
            CPU_PRI: if (w_wait_nxt >= c_WAIT_MAX) r_state <= NIC_PRI;
            NIC_PRI: if (w_nic_gnt) r_state <= CPU_PRI;
            default: r_state <= CPU_PRI;
         endcase
      end
   end

   // The read tag steers the single DMEM return bus to whoever issued the read.
   assign cpu_rvalid = r_rd_vld & ~r_rd_nic;
   assign nic_rvalid = r_rd_vld &  r_rd_nic;
   assign cpu_rdata  = cpu_rvalid ? dmem_rdata : '0;
   assign nic_rdata  = nic_rvalid ? dmem_rdata : '0;

`ifdef DMEM_ARB_STAT_EN
   logic [15:0] r_conflict_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_conflict_cnt <= 16'd0;
      end else if (cpu_memEn && nic_req && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire
